// File: rtl/fifo_pkg.sv
// fifo_pkg: types and helpers shared by the single- and dual-clock FIFOs.
package fifo_pkg;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_fifo_thr_if.sv
// sync_fifo_thr_if: push/pop, threshold and status bundle of sync_fifo_thr.
interface sync_fifo_thr_if #(parameter int DATA_WIDTH = 8, parameter int ADDR_WIDTH = 4);
  localparam int LW = ADDR_WIDTH + 1;
  logic flush, wr_en, rd_en, rd_valid;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [LW-1:0] afull_thr, aempty_thr, level;
  modport master(
    output flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr,
    input rd_data, rd_valid, level, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave(
    input flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr,
    output rd_data, rd_valid, level, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: 1W1R storage, synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with level, runtime thresholds, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read stage.
module sync_fifo_thr
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_thr_if.slave bus
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic overflow, underflow;
  logic [DATA_WIDTH-1:0] mem_q;
  logic wr_acc, rd_acc;
  fifo_status_t st;
  always_comb begin
    st.full = level == LW'(DEPTH);
    st.empty = level == '0;
    st.almost_full = level >= bus.afull_thr;
    st.almost_empty = level <= bus.aempty_thr;
    st.overflow = overflow;
    st.underflow = underflow;
  end
  // flush masks both requests so nothing is stored or flagged in that cycle
  assign wr_acc = bus.wr_en & ~st.full & ~bus.flush;
  assign rd_acc = bus.rd_en & ~st.empty & ~bus.flush;
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(bus.wr_data),
    .rd_addr(rd_ptr),
    .rd_data(mem_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_acc);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_acc);
      level <= level + LW'(wr_acc) - LW'(rd_acc);
      overflow <= overflow | (bus.wr_en & st.full);
      underflow <= underflow | (bus.rd_en & st.empty);
    end
`ifdef SYNC_FIFO_FWFT_EN
  // head word is presented directly; zero while empty keeps rd_data defined after reset
  assign bus.rd_valid = ~st.empty;
  assign bus.rd_data = st.empty ? '0 : mem_q;
`else
  logic rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else if (bus.flush) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q;
    end
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data = rd_data_q;
`endif
  assign bus.level = level;
  assign bus.full = st.full;
  assign bus.empty = st.empty;
  assign bus.almost_full = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.overflow = st.overflow;
  assign bus.underflow = st.underflow;
endmodule
